// File: rtl/field_colour_ctl.sv
// Two-stage colour resolver for the minefield draw chain: layer priority, palette
// lookup through colour_pkg, and the game FSM with the frame-counted loss blink.

package colour_pkg;
    localparam logic [11:0] BLACK        = 12'h111;
    localparam logic [11:0] RED          = 12'hf00;
    localparam logic [11:0] BUTTON_BACK  = 12'hddd;
    localparam logic [11:0] BUTTON_WHITE = 12'hfff;
    localparam logic [11:0] BUTTON_GRAY  = 12'h555;
    localparam logic [11:0] NUM_1        = 12'h11b;
    localparam logic [11:0] NUM_2        = 12'h0a6;
    localparam logic [11:0] NUM_3        = 12'h555;
    localparam logic [11:0] NUM_4        = 12'h413;
    localparam logic [11:0] NUM_5        = 12'h023;
    localparam logic [11:0] NUM_6        = 12'h999;
    localparam logic [11:0] NUM_7        = 12'ha51;
    localparam logic [11:0] NUM_DEFAULT  = 12'h000;
endpackage

module field_colour_ctl #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        button_req,
    input  logic [1:0]  button_shade,
    input  logic        num_req,
    input  logic [3:0]  num_val,
    input  logic        mine_req,
    input  logic        game_lost,
    input  logic        game_won,
    input  logic        game_restart,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [1:0]  game_state
);
    import colour_pkg::*;

    typedef enum logic [1:0] {PLAY = 2'd0, LOST = 2'd1, WON = 2'd2} state_e;
    typedef enum logic [1:0] {SEL_BG, SEL_BTN, SEL_NUM, SEL_MINE} sel_e;

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    // stage 1
    logic [10:0] hcount_d1, vcount_d1;
    logic        hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
    logic [11:0] rgb_d1;
    logic [3:0]  num_val_d1;
    logic [1:0]  shade_d1;
    sel_e        sel_d1, sel_in;
    logic        blank_d1;

    // game state and blink sequencer
    state_e      state_q, state_n;
    logic [7:0]  frame_cnt, frame_cnt_n;
    logic        blink_phase, blink_phase_n;
    logic        frame_tick;
    logic [11:0] colour;

    assign sel_in = mine_req   ? SEL_MINE :
                    num_req    ? SEL_NUM  :
                    button_req ? SEL_BTN  : SEL_BG;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values,
        // which is what makes the two stages line up exactly.
        if (rst) begin
            hcount_d1  <= '0;
            vcount_d1  <= '0;
            hsync_d1   <= 1'b0;
            vsync_d1   <= 1'b0;
            hblnk_d1   <= 1'b0;
            vblnk_d1   <= 1'b0;
            rgb_d1     <= '0;
            num_val_d1 <= '0;
            shade_d1   <= '0;
            sel_d1     <= SEL_BG;
            blank_d1   <= 1'b0;
        end else begin
            hcount_d1  <= hcount_in;
            vcount_d1  <= vcount_in;
            hsync_d1   <= hsync_in;
            vsync_d1   <= vsync_in;
            hblnk_d1   <= hblnk_in;
            vblnk_d1   <= vblnk_in;
            rgb_d1     <= rgb_in;
            num_val_d1 <= num_val;
            shade_d1   <= button_shade;
            sel_d1     <= sel_in;
            blank_d1   <= hblnk_in | vblnk_in;
        end
    end

    // vblnk_d1 doubles as the registered copy used for frame-start detection
    assign frame_tick = vblnk_in & ~vblnk_d1;

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
        state_n       = state_q;
        frame_cnt_n   = frame_cnt;
        blink_phase_n = blink_phase;
        case (state_q)
            PLAY: begin
                frame_cnt_n   = '0;
                blink_phase_n = 1'b0;
                if (game_restart) begin
                    state_n = PLAY;
                end else if (game_lost) begin
                    state_n       = LOST;
                    blink_phase_n = 1'b1;
                end else if (game_won) begin
                    state_n = WON;
                end
            end
            LOST: begin
                if (game_restart) begin
                    state_n       = PLAY;
                    frame_cnt_n   = '0;
                    blink_phase_n = 1'b0;
                end else if (frame_tick) begin
                    if (frame_cnt == LAST_FRAME) begin
                        frame_cnt_n   = '0;
                        blink_phase_n = ~blink_phase;
                    end else begin
                        frame_cnt_n = frame_cnt + 8'd1;
                    end
                end
            end
            WON: begin
                frame_cnt_n   = '0;
                blink_phase_n = 1'b0;
                if (game_restart) state_n = PLAY;
            end
            default: begin
                state_n       = PLAY;
                frame_cnt_n   = '0;
                blink_phase_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLAY;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            state_q     <= state_n;
            frame_cnt   <= frame_cnt_n;
            blink_phase <= blink_phase_n;
        end
    end

    assign game_state = state_q;

    // blink_phase is held at 0 outside LOST, so it alone selects the mine colour
    always_comb begin
        colour = rgb_d1;
        case (sel_d1)
            SEL_MINE: colour = blink_phase ? RED : BLACK;
            SEL_NUM: begin
                case (num_val_d1)
                    4'd1:    colour = NUM_1;
                    4'd2:    colour = NUM_2;
                    4'd3:    colour = NUM_3;
                    4'd4:    colour = NUM_4;
                    4'd5:    colour = NUM_5;
                    4'd6:    colour = NUM_6;
                    4'd7:    colour = NUM_7;
                    default: colour = NUM_DEFAULT;
                endcase
            end
            SEL_BTN: begin
                case (shade_d1)
                    2'd1:    colour = BUTTON_WHITE;
                    2'd2:    colour = BUTTON_GRAY;
                    default: colour = BUTTON_BACK;
                endcase
            end
            default: colour = rgb_d1;
        endcase
        if (blank_d1) colour = 12'h000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_d1;
            vcount_out <= vcount_d1;
            hsync_out  <= hsync_d1;
            vsync_out  <= vsync_d1;
            hblnk_out  <= hblnk_d1;
            vblnk_out  <= vblnk_d1;
            rgb_out    <= colour;
        end
    end

endmodule

// File: tb/tb_field_colour_ctl.sv
// Scoreboard bench for field_colour_ctl: stimulus pushes expected pixels two cycles
// ahead, a negedge monitor pops and compares; game_state is checked directly.

module tb_field_colour_ctl;

    localparam logic [11:0] C_BLACK = 12'h111;
    localparam logic [11:0] C_RED   = 12'hf00;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        button_req, num_req, mine_req;
    logic [1:0]  button_shade;
    logic [3:0]  num_val;
    logic        game_lost, game_won, game_restart;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [1:0]  game_state;

    field_colour_ctl #(.BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .button_req(button_req), .button_shade(button_shade),
        .num_req(num_req), .num_val(num_val), .mine_req(mine_req),
        .game_lost(game_lost), .game_won(game_won), .game_restart(game_restart),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .game_state(game_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [25:0] tim;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    logic [11:0] num_tab [16];
    logic [11:0] shade_tab [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // output of an input cycle appears after the second following edge
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due != cyc)
                check({mon_e.name, "_late"}, 32'(cyc), 32'(mon_e.due));
            check({mon_e.name, "_rgb"}, 32'(rgb_out), 32'(mon_e.rgb));
            check({mon_e.name, "_timing"},
                  32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                  32'(mon_e.tim));
        end
    end

    task automatic issue(input logic [11:0] exp_rgb, input string name);
        exp_t e;
        e.due  = cyc + 2;
        e.rgb  = exp_rgb;
        e.tim  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
        e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        game_lost    = 1'b0;
        game_won     = 1'b0;
        game_restart = 1'b0;
        hcount_in    = hcount_in + 11'd7;
        vcount_in    = vcount_in + 11'd1;
        hsync_in     = hcount_in[2];
        vsync_in     = hcount_in[4];
    endtask

    task automatic clr_req();
        mine_req   = 1'b0;
        num_req    = 1'b0;
        button_req = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "run timed out");
    end

    initial begin
        num_tab = '{12'h000, 12'h11b, 12'h0a6, 12'h555, 12'h413, 12'h023, 12'h999, 12'ha51,
                    12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        shade_tab = '{12'hddd, 12'hfff, 12'h555, 12'hddd};

        rst = 1'b1;
        hcount_in = 11'd100; vcount_in = 11'd50;
        hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'h5a5; button_shade = 2'd1; num_val = 4'd3;
        button_req = 1'b1; num_req = 1'b1; mine_req = 1'b1;
        game_lost = 1'b0; game_won = 1'b0; game_restart = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", 32'(rgb_out), 32'h000);
        check("reset_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("reset_state", 32'(game_state), 32'd0);
        rst = 1'b0;

        // priority and blanking
        num_val = 4'd1;
        issue(C_BLACK, "prio_all");
        hblnk_in = 1'b1;
        issue(12'h000, "prio_hblank");
        hblnk_in = 1'b0; vblnk_in = 1'b1;
        issue(12'h000, "prio_vblank");
        vblnk_in = 1'b0;

        // number map sweep
        clr_req(); num_req = 1'b1; rgb_in = 12'h7e7;
        for (int v = 0; v < 16; v++) begin
            num_val = 4'(v);
            issue(num_tab[v], $sformatf("num_%0d", v));
        end

        // button shades and background pass-through
        clr_req(); button_req = 1'b1;
        for (int s = 0; s < 4; s++) begin
            button_shade = 2'(s);
            issue(shade_tab[s], $sformatf("shade_%0d", s));
        end
        clr_req();
        rgb_in = 12'habc; issue(12'habc, "bg_abc");
        rgb_in = 12'h123; issue(12'h123, "bg_123");

        // loss blink, BLINK_FRAMES = 2
        rgb_in = 12'h3c3; game_lost = 1'b1;
        issue(12'h3c3, "lost_pulse");
        check("state_lost", 32'(game_state), 32'd1);
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < 3; p++) begin
                mine_req = 1'b1;
                if (k == 2 && p == 0) game_lost = 1'b1;
                issue(((k / 2) % 2 == 0) ? C_RED : C_BLACK, $sformatf("blink_f%0d_p%0d", k, p));
            end
            if (k == 2) check("state_lost_again", 32'(game_state), 32'd1);
            if (k < 5) begin
                vblnk_in = 1'b1;
                issue(12'h000, $sformatf("blink_tick%0d", k));
                vblnk_in = 1'b0;
            end
        end

        // reset while LOST with the mine showing RED
        drain();
        rst = 1'b1; mine_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_rgb", 32'(rgb_out), 32'h000);
        check("midrst_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("midrst_state", 32'(game_state), 32'd0);
        issue(C_BLACK, "post_rst_mine0");
        issue(C_BLACK, "post_rst_mine1");
        check("post_rst_state", 32'(game_state), 32'd0);

        // event priority and ignored events
        clr_req(); rgb_in = 12'h246;
        game_lost = 1'b1; game_won = 1'b1;
        issue(12'h246, "ev_lost_won");
        check("ev_lost_won_state", 32'(game_state), 32'd1);
        game_won = 1'b1;
        issue(12'h246, "ev_won_in_lost");
        check("ev_won_in_lost_state", 32'(game_state), 32'd1);
        game_restart = 1'b1;
        issue(12'h246, "ev_restart");
        check("ev_restart_state", 32'(game_state), 32'd0);
        mine_req = 1'b1;
        issue(C_BLACK, "ev_mine_after_restart");
        mine_req = 1'b0;
        game_restart = 1'b1; game_lost = 1'b1;
        issue(12'h246, "ev_restart_lost");
        check("ev_restart_lost_state", 32'(game_state), 32'd0);
        game_won = 1'b1;
        issue(12'h246, "ev_won");
        check("ev_won_state", 32'(game_state), 32'd2);
        mine_req = 1'b1;
        issue(C_BLACK, "ev_mine_won");
        mine_req = 1'b0;
        game_lost = 1'b1;
        issue(12'h246, "ev_lost_in_won");
        check("ev_lost_in_won_state", 32'(game_state), 32'd2);
        game_restart = 1'b1;
        issue(12'h246, "ev_restart_won");
        check("ev_restart_won_state", 32'(game_state), 32'd0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
